// File: rtl/aes_pkg.sv
// Shared AES definitions for the InvMixColumns engine.
//   aes_state_t : 4x4 byte state, indexed [row][col]; column c is s[0..3][c].
//   AES_POLY    : low byte of the GF(2^8) reduction polynomial 0x11b.
//   ST_*        : FSM encodings of the iterative engine.
//   xtime, gf_mul9/11/13/14 : constant multiplies built from repeated xtime.
package aes_pkg;

    typedef logic [3:0][3:0][7:0] aes_state_t;

    localparam logic [7:0] AES_POLY = 8'h1b;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Multiply by x, reducing by 0x11b when bit 7 falls off the top.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// Combinational InvMixColumns of a single column.
//   col_in  : a0..a3, element r is row r of the column.
//   col_out : r0..r3, the column multiplied by the inverse MixColumns matrix.
module aes_inv_mix_column
    import aes_pkg::*;
(
    input  logic [3:0][7:0] col_in,
    output logic [3:0][7:0] col_out
);

    assign col_out[0] = gf_mul14(col_in[0]) ^ gf_mul11(col_in[1]) ^
                        gf_mul13(col_in[2]) ^ gf_mul9(col_in[3]);
    assign col_out[1] = gf_mul9(col_in[0])  ^ gf_mul14(col_in[1]) ^
                        gf_mul11(col_in[2]) ^ gf_mul13(col_in[3]);
    assign col_out[2] = gf_mul13(col_in[0]) ^ gf_mul9(col_in[1])  ^
                        gf_mul14(col_in[2]) ^ gf_mul11(col_in[3]);
    assign col_out[3] = gf_mul11(col_in[0]) ^ gf_mul13(col_in[1]) ^
                        gf_mul9(col_in[2])  ^ gf_mul14(col_in[3]);

endmodule

// File: rtl/aes_inv_mixcolumns_seq.sv
// Iterative AES InvMixColumns engine, COLS_PER_CYCLE columns per clock.
//   clk, rst_n           : rising-edge clock, synchronous active-low reset.
//   in_valid/in_ready    : input handshake carrying state_in ([row][col]).
//   out_valid/out_ready  : output handshake carrying state_out.
//   dbg_state            : current FSM state (ST_IDLE/ST_BUSY/ST_DONE).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer keeps valid and its data stable until that edge; ready
// may depend combinationally on the consumer's ready (in_ready follows
// out_ready in DONE so a new block is taken in the same cycle the result
// leaves). state_in is latched on acceptance and never used again.
module aes_inv_mixcolumns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0][3:0][7:0]  state_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0][3:0][7:0]  state_out,
    output logic [1:0]            dbg_state
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // With 4 lanes the step truncates to 0 and the single group is group 0.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);

    logic [1:0]  state;
    logic [1:0]  col_cnt;
    aes_state_t  src_reg;
    aes_state_t  res_reg;
    logic        accept;

    logic [COLS_PER_CYCLE-1:0][1:0]      lane_idx;
    logic [COLS_PER_CYCLE-1:0][3:0][7:0] lane_out;

    // Lane g handles column col_cnt+g of the latched source state.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        logic [1:0]      idx;
        logic [3:0][7:0] cin;
        logic [3:0][7:0] cout;

        assign idx = col_cnt + 2'(g);

        always_comb begin
            cin = '0;
            for (int r = 0; r < 4; r++) begin
                cin[r] = src_reg[r][idx];
            end
        end

        aes_inv_mix_column u_col (
            .col_in  (cin),
            .col_out (cout)
        );

        assign lane_idx[g] = idx;
        assign lane_out[g] = cout;
    end

    assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    assign out_valid = (state == ST_DONE);
    assign state_out = res_reg;
    assign dbg_state = state;
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            col_cnt <= 2'd0;
            src_reg <= '0;
            res_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        src_reg <= state_in;
                        col_cnt <= 2'd0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                        for (int r = 0; r < 4; r++) begin
                            res_reg[r][lane_idx[g]] <= lane_out[g][r];
                        end
                    end
                    col_cnt <= col_cnt + STEP;
                    if (col_cnt == LAST_GRP) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Re-accepting here skips the IDLE bubble in a stream.
                    if (accept) begin
                        src_reg <= state_in;
                        col_cnt <= 2'd0;
                        state   <= ST_BUSY;
                    end else if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_mixcolumns_seq.sv
module tb_aes_inv_mixcolumns_seq;
    import aes_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    aes_state_t state_in = '0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic in_ready1, out_valid1, in_ready2, out_valid2, in_ready4, out_valid4;
    aes_state_t state_out1, state_out2, state_out4;
    logic [1:0] dbg1, dbg2, dbg4;

    aes_inv_mixcolumns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .state_in(state_in), .out_valid(out_valid1), .out_ready(out_ready),
        .state_out(state_out1), .dbg_state(dbg1));
    aes_inv_mixcolumns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .state_in(state_in), .out_valid(out_valid2), .out_ready(out_ready),
        .state_out(state_out2), .dbg_state(dbg2));
    aes_inv_mixcolumns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .state_in(state_in), .out_valid(out_valid4), .out_ready(out_ready),
        .state_out(state_out4), .dbg_state(dbg4));

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Generic shift-and-add GF(2^8) product modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] t;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            t = {aa, 1'b0};
            if (t[8]) t = t ^ 9'h11b;
            aa = t[7:0];
        end
        return p;
    endfunction

    // Circulant matrix product: row r coefficient for input k is base[(k-r) mod 4].
    function automatic aes_state_t mat_mul(input aes_state_t s, input logic [31:0] coefs);
        aes_state_t res;
        logic [7:0] base [4];
        logic [7:0] acc;
        for (int i = 0; i < 4; i++) base[i] = coefs[31-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(base[(k - r + 4) % 4], s[k][c]);
                res[r][c] = acc;
            end
        end
        return res;
    endfunction

    function automatic aes_state_t ref_inv(input aes_state_t s);
        return mat_mul(s, 32'h0e0b0d09);
    endfunction

    function automatic aes_state_t ref_fwd(input aes_state_t s);
        return mat_mul(s, 32'h02030101);
    endfunction

    function automatic aes_state_t from_cols(input logic [31:0] c0, input logic [31:0] c1,
                                             input logic [31:0] c2, input logic [31:0] c3);
        aes_state_t s;
        logic [31:0] col [4];
        col[0] = c0; col[1] = c1; col[2] = c2; col[3] = c3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = col[c][31-8*r -: 8];
        return s;
    endfunction

    function automatic aes_state_t rand_state();
        aes_state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = 8'($urandom_range(0, 255));
        return s;
    endfunction

    // ---------------- scoreboard (dut1) ----------------
    logic [127:0] exp_q[$];
    logic [127:0] src_q[$];
    logic [127:0] got_q[$];
    int acc_cyc_q[$];
    int rise_cyc_q[$];
    logic prev_ov = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready1) begin
                exp_q.push_back(ref_inv(state_in));
                src_q.push_back(state_in);
                acc_cyc_q.push_back(cyc + 1);
            end
            if (out_valid1 && out_ready) got_q.push_back(state_out1);
            if (out_valid1 && !prev_ov) rise_cyc_q.push_back(cyc);
        end
        prev_ov = out_valid1;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_sb();
        exp_q.delete(); src_q.delete(); got_q.delete();
        acc_cyc_q.delete(); rise_cyc_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        state_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_sb();
    endtask

    // Returns one time unit after the accepting edge with in_valid dropped.
    task automatic send(input aes_state_t blk, output bit ok);
        logic rdy;
        ok = 1'b0;
        in_valid = 1'b1;
        state_in = blk;
        for (int i = 0; i < 50; i++) begin
            #1;
            rdy = in_ready1;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b%b%b exp 111", in_ready1, in_ready2, in_ready4);
        end
        checks++;
        if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0 || out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b%b%b exp 000", out_valid1, out_valid2, out_valid4);
        end
        checks++;
        if (state_out1 !== '0 || state_out2 !== '0 || state_out4 !== '0) begin
            errors++;
            $display("FAIL reset_state_out got %h exp 0", state_out1);
        end
        checks++;
        if (dbg1 !== 2'd0) begin
            errors++;
            $display("FAIL reset_dbg_state got %0d exp 0", dbg1);
        end
    endtask

    task automatic test_kat();
        aes_state_t blk, exp;
        bit ok;
        do_reset();
        blk = from_cols(32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101);
        exp = from_cols(32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101);
        send(blk, ok);
        wait_got(1, 30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL kat_timeout got %0d outputs exp 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp) begin
                errors++;
                $display("FAIL kat_result got %h exp %h", got_q[0], exp);
            end
            checks++;
            if (rise_cyc_q.size() != 1 || acc_cyc_q.size() != 1 ||
                rise_cyc_q[0] - acc_cyc_q[0] != 4) begin
                errors++;
                $display("FAIL kat_latency got %0d exp 4",
                         (rise_cyc_q.size() > 0 && acc_cyc_q.size() > 0) ? rise_cyc_q[0] - acc_cyc_q[0] : -1);
            end
        end
    endtask

    task automatic test_widths();
        aes_state_t blk, exp, res1, res2, res4;
        int lat1, lat2, lat4;
        bit ok;
        do_reset();
        blk = from_cols(32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6);
        exp = from_cols(32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6);
        lat1 = -1; lat2 = -1; lat4 = -1;
        res1 = '0; res2 = '0; res4 = '0;
        send(blk, ok);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (lat1 < 0 && out_valid1) begin lat1 = k; res1 = state_out1; end
            if (lat2 < 0 && out_valid2) begin lat2 = k; res2 = state_out2; end
            if (lat4 < 0 && out_valid4) begin lat4 = k; res4 = state_out4; end
        end
        checks++;
        if (lat1 != 4) begin errors++; $display("FAIL width1_latency got %0d exp 4", lat1); end
        checks++;
        if (lat2 != 2) begin errors++; $display("FAIL width2_latency got %0d exp 2", lat2); end
        checks++;
        if (lat4 != 1) begin errors++; $display("FAIL width4_latency got %0d exp 1", lat4); end
        checks++;
        if (res1 !== exp) begin errors++; $display("FAIL width1_result got %h exp %h", res1, exp); end
        checks++;
        if (res2 !== exp) begin errors++; $display("FAIL width2_result got %h exp %h", res2, exp); end
        checks++;
        if (res4 !== exp) begin errors++; $display("FAIL width4_result got %h exp %h", res4, exp); end
    endtask

    task automatic test_backpressure();
        aes_state_t blk, exp;
        bit ok, seen;
        do_reset();
        out_ready = 1'b0;
        blk = rand_state();
        exp = ref_inv(blk);
        send(blk, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid1) begin seen = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_timeout got out_valid 0 exp 1");
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            state_in = rand_state();
            #1;
            checks++;
            if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_flags cycle %0d got ov=%b ir=%b exp ov=1 ir=0", i, out_valid1, in_ready1);
            end
            checks++;
            if (state_out1 !== exp) begin
                errors++;
                $display("FAIL bp_hold_data cycle %0d got %h exp %h", i, state_out1, exp);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid1 !== 1'b0 || got_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL bp_release got ov=%b outputs=%0d accepts=%0d exp ov=0 outputs=1 accepts=1",
                     out_valid1, got_q.size(), exp_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp) begin
                errors++;
                $display("FAIL bp_result got %h exp %h", got_q[0], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(rand_state(), ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_accept block %0d got no accept exp accept", i);
            end
        end
        wait_got(8, 100, ok);
        checks++;
        if (!ok || exp_q.size() != 8 || acc_cyc_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_count got outputs=%0d accepts=%0d exp 8", got_q.size(), exp_q.size());
        end else begin
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (acc_cyc_q[i] - acc_cyc_q[i-1] != 5) begin
                    errors++;
                    $display("FAIL b2b_period block %0d got %0d exp 5", i, acc_cyc_q[i] - acc_cyc_q[i-1]);
                end
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_result block %0d got %h exp %h", i, got_q[i], exp_q[i]);
                end
                checks++;
                if (ref_fwd(got_q[i]) !== src_q[i]) begin
                    errors++;
                    $display("FAIL b2b_roundtrip block %0d got %h exp %h", i, ref_fwd(got_q[i]), src_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        send(from_cols(32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101), ok);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || dbg1 !== 2'd0) begin
            errors++;
            $display("FAIL midreset_flags got ir=%b ov=%b st=%0d exp ir=1 ov=0 st=0", in_ready1, out_valid1, dbg1);
        end
        checks++;
        if (state_out1 !== '0) begin
            errors++;
            $display("FAIL midreset_data got %h exp 0", state_out1);
        end
        rst_n = 1'b1;
        clear_sb();
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (rise_cyc_q.size() != 0 || got_q.size() != 0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale got rises=%0d outputs=%0d exp 0", rise_cyc_q.size(), got_q.size());
        end
    endtask

    task automatic test_edge_values();
        aes_state_t all80;
        bit ok;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                all80[r][c] = 8'h80;
        do_reset();
        send('0, ok);
        send(all80, ok);
        wait_got(2, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL edge_timeout got %0d outputs exp 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 128'h0) begin
                errors++;
                $display("FAIL edge_zero got %h exp 0", got_q[0]);
            end
            checks++;
            if (got_q[1] !== {16{8'h80}}) begin
                errors++;
                $display("FAIL edge_0x80 got %h exp %h", got_q[1], {16{8'h80}});
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_kat();
        test_widths();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_edge_values();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
